// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO; result commits MULT_CYCLES/DIV_CYCLES edges after the start edge.
// No backpressure: md_stall asks the hazard unit to hold D while an op is starting or in flight.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    pend_hi_q, pend_hi_d;
    logic [31:0]    pend_lo_q, pend_lo_d;
    logic           pend_valid_q, pend_valid_d;

    logic [63:0]    prod_s, prod_u;
    logic           is_sgn, a_neg, b_neg;
    logic [31:0]    dvd, dvs, dvs_safe, uq, ur, quo, rem;
    logic           commit, accept;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        prod_s   = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
        prod_u   = {32'd0, opa} * {32'd0, opb};
        is_sgn   = (md_op == OP_DIV);
        a_neg    = is_sgn & opa[31];
        b_neg    = is_sgn & opb[31];
        dvd      = a_neg ? (32'd0 - opa) : opa;
        dvs      = b_neg ? (32'd0 - opb) : opb;
        dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
        uq       = dvd / dvs_safe;
        ur       = dvd % dvs_safe;
        quo      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem      = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;

        commit = (state_q == S_RUN) && (cnt_q == CW'(1));
        accept = md_start && ((state_q == S_IDLE) || commit);

        if (state_q == S_RUN) begin
            cnt_d = cnt_q - CW'(1);
            if (commit) begin
                state_d = S_IDLE;
                if (pend_valid_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end

        // A start on the commit edge is accepted; an MTHI/MTLO there is younger and wins.
        if (accept) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d    = (md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                    pend_lo_d    = (md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                    pend_valid_d = 1'b1;
                    cnt_d        = CW'(MULT_CYCLES);
                    state_d      = S_RUN;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d    = rem;
                    pend_lo_d    = quo;
                    pend_valid_d = (opb != 32'd0);
                    cnt_d        = CW'(DIV_CYCLES);
                    state_d      = S_RUN;
                end
                OP_MTHI: hi_d = opa;
                OP_MTLO: lo_d = opa;
                default: ;
            endcase
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    // The start cycle must stall too: busy only rises after the start edge.
    assign md_stall = md_use_D & (busy_q | md_start);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed cases plus random traffic against a commit-time reference model.
module tb_md_unit_ctrl;

    localparam int MN = 5;
    localparam int DN = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit_ctrl #(.MULT_CYCLES(MN), .DIV_CYCLES(DN)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_start (md_start),
        .md_op    (md_op),
        .opa      (opa),
        .opb      (opb),
        .md_use_D (md_use_D),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: an op accepted at edge e commits at edge e+N; starts are taken only when nothing is pending.
    bit          m_run;
    int          m_done;
    int          ecnt;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok;

    task automatic ref_reset();
        m_run = 0; m_done = 0; ecnt = 0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_ok = 0;
    endtask

    task automatic ref_edge(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        ecnt++;
        if (m_run && ecnt == m_done) begin
            m_run = 0;
            if (p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
        if (!m_run && st) begin
            case (op)
                3'd0, 3'd1: begin
                    sa = (op == 3'd0) ? longint'($signed(a)) : longint'(a);
                    sb = (op == 3'd0) ? longint'($signed(b)) : longint'(b);
                    p  = sa * sb;
                    p_hi = p[63:32]; p_lo = p[31:0]; p_ok = 1;
                    m_run = 1; m_done = ecnt + MN;
                end
                3'd2, 3'd3: begin
                    p_ok = (b != 0);
                    if (p_ok) begin
                        sa = (op == 3'd2) ? longint'($signed(a)) : longint'(a);
                        sb = (op == 3'd2) ? longint'($signed(b)) : longint'(b);
                        q = sa / sb;
                        r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                    m_run = 1; m_done = ecnt + DN;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit ud);
        md_start = st; md_op = op; opa = a; opb = b; md_use_D = ud;
        #1;
        chk("stall", {63'd0, md_stall}, {63'd0, ud & (m_run | st)});
        @(posedge clk);
        ref_edge(st, op, a, b);
        @(negedge clk);
        chk("busy", {63'd0, busy}, {63'd0, m_run});
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 3'd0, $urandom, $urandom, 0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: pick_val = 32'd0;
            1: pick_val = 32'd1;
            2: pick_val = 32'hFFFFFFFF;
            3: pick_val = 32'h80000000;
            4: pick_val = $urandom_range(0, 20);
            default: pick_val = $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0; md_start = 0; md_op = 0; opa = 0; opb = 0; md_use_D = 0;
        ref_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        md_use_D = 1; #1;
        chk("rst_stall", {63'd0, md_stall}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        cyc(1, 3'd0, 32'hFFFFFFFF, 32'd2, 0); idle(MN);
        chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFFFFFE);
        cyc(1, 3'd1, 32'hFFFFFFFF, 32'd2, 0); idle(MN);
        chk("multu_hi", {32'd0, hi}, 64'h1);
        chk("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);

        cyc(1, 3'd2, 32'hFFFFFFF9, 32'd2, 0); idle(DN);
        chk("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
        cyc(1, 3'd3, 32'd7, 32'd2, 0); idle(DN);
        chk("divu_lo", {32'd0, lo}, 64'd3);
        chk("divu_hi", {32'd0, hi}, 64'd1);
        cyc(1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 0); idle(DN);
        chk("divovf_lo", {32'd0, lo}, 64'h80000000);
        chk("divovf_hi", {32'd0, hi}, 64'd0);

        cyc(1, 3'd4, 32'h11111111, 32'd0, 0);
        cyc(1, 3'd5, 32'h22222222, 32'd0, 0);
        cyc(1, 3'd3, 32'd99, 32'd0, 0); idle(DN);
        chk("div0_hi", {32'd0, hi}, 64'h11111111);
        chk("div0_lo", {32'd0, lo}, 64'h22222222);

        cyc(1, 3'd0, 32'd6, 32'd7, 1);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);
        cyc(1, 3'd5, 32'hDEAD, 32'd0, 1);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);
        cyc(0, 3'd0, 32'd0, 32'd0, 1);
        chk("stall_lo", {32'd0, lo}, 64'd42);

        cyc(1, 3'd0, 32'd3, 32'd4, 0); idle(MN);
        chk("b2b_lo12", {32'd0, lo}, 64'd12);
        cyc(1, 3'd5, 32'h55, 32'd0, 0);
        chk("b2b_lo55", {32'd0, lo}, 64'h55);
        chk("b2b_hi", {32'd0, hi}, 64'd0);

        cyc(1, 3'd0, 32'd2, 32'd5, 0); idle(MN - 1);
        cyc(1, 3'd1, 32'd9, 32'd9, 0);
        chk("commit_edge_busy", {63'd0, busy}, 64'd1);
        idle(MN);

        cyc(1, 3'd4, 32'hABCD, 32'd0, 0);
        cyc(1, 3'd2, 32'd100, 32'd7, 0); idle(3);
        reset_n = 1'b0; #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_hi", {32'd0, hi}, 64'd0);
        chk("mid_rst_lo", {32'd0, lo}, 64'd0);
        ref_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(DN + 2);

        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), pick_val(), pick_val(),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
